// File: rtl/scpad_tile_sequencer_if.sv
// rtl/scpad_tile_sequencer_if.sv - descriptor request and SRAM beat stream bundle for the tile sequencer
interface scpad_tile_sequencer_if #(
    parameter int NUM_COLS      = 32,
    parameter int ROW_IDX_WIDTH = 14,
    parameter int COL_IDX_WIDTH = 5,
    parameter int MAX_DIM_WIDTH = 5
);
    logic                              req_valid;
    logic                              req_ready;
    logic [ROW_IDX_WIDTH-1:0]          req_base_row;
    logic [MAX_DIM_WIDTH-1:0]          req_rows_m1;
    logic [MAX_DIM_WIDTH-1:0]          req_cols_m1;
    logic                              req_transpose;
    logic                              req_write;

    logic                              out_valid;
    logic                              out_ready;
    logic                              out_write;
    logic [NUM_COLS*ROW_IDX_WIDTH-1:0] out_slot;
    logic [NUM_COLS*COL_IDX_WIDTH-1:0] out_shift;
    logic [NUM_COLS-1:0]               out_mask;
    logic [MAX_DIM_WIDTH-1:0]          out_beat;
    logic                              out_last;

    // master: frontend arbiter plus SRAM controller side; slave: the sequencer
    modport master (
        output req_valid, req_base_row, req_rows_m1, req_cols_m1, req_transpose, req_write,
        output out_ready,
        input  req_ready,
        input  out_valid, out_write, out_slot, out_shift, out_mask, out_beat, out_last
    );

    modport slave (
        input  req_valid, req_base_row, req_rows_m1, req_cols_m1, req_transpose, req_write,
        input  out_ready,
        output req_ready,
        output out_valid, out_write, out_slot, out_shift, out_mask, out_beat, out_last
    );
endinterface

// File: rtl/scpad_tile_sequencer.sv
// rtl/scpad_tile_sequencer.sv - expands a tile descriptor into diagonally swizzled per-bank SRAM beats
module scpad_tile_sequencer #(
    parameter int NUM_COLS      = 32,
    parameter int ROW_IDX_WIDTH = 14,
    parameter int COL_IDX_WIDTH = 5,
    parameter int MAX_DIM_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  nRST,
    scpad_tile_sequencer_if.slave bus,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                   state;
    logic [ROW_IDX_WIDTH-1:0] base_row;
    logic [MAX_DIM_WIDTH-1:0] rows_m1;
    logic [MAX_DIM_WIDTH-1:0] cols_m1;
    logic                     transpose;
    logic                     write_q;
    logic [MAX_DIM_WIDTH-1:0] beat;
    logic                     done_q;

    logic                     issuing;
    logic [MAX_DIM_WIDTH-1:0] last_idx;
    logic                     last;
    logic [COL_IDX_WIDTH-1:0] beat_lane;

    assign issuing   = (state == ISSUE);
    assign last_idx  = transpose ? cols_m1 : rows_m1;
    assign last      = (beat == last_idx);
    assign beat_lane = COL_IDX_WIDTH'(beat);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            base_row  <= '0;
            rows_m1   <= '0;
            cols_m1   <= '0;
            transpose <= 1'b0;
            write_q   <= 1'b0;
            beat      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base_row  <= bus.req_base_row;
                        rows_m1   <= bus.req_rows_m1;
                        cols_m1   <= bus.req_cols_m1;
                        transpose <= bus.req_transpose;
                        write_q   <= bus.req_write;
                        beat      <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.out_ready) begin
                        if (last) begin
                            state  <= IDLE;
                            beat   <= '0;
                            done_q <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [NUM_COLS*ROW_IDX_WIDTH-1:0] slot_v;
    logic [NUM_COLS*COL_IDX_WIDTH-1:0] shift_v;
    logic [NUM_COLS-1:0]               mask_v;

    // Bank b holds tile index (b - beat) along the swept axis because of the diagonal swizzle.
    for (genvar b = 0; b < NUM_COLS; b++) begin : g_bank
        logic [COL_IDX_WIDTH-1:0] lane;
        assign lane = COL_IDX_WIDTH'(b) - beat_lane;
        assign slot_v[b*ROW_IDX_WIDTH +: ROW_IDX_WIDTH] =
            transpose ? (base_row + ROW_IDX_WIDTH'(lane)) : (base_row + ROW_IDX_WIDTH'(beat));
        assign shift_v[b*COL_IDX_WIDTH +: COL_IDX_WIDTH] = lane;
        assign mask_v[b] =
            transpose ? (32'(lane) <= 32'(rows_m1)) : (32'(lane) <= 32'(cols_m1));
    end

    assign bus.req_ready = !issuing;
    assign bus.out_valid = issuing;
    assign bus.out_write = issuing & write_q;
    assign bus.out_slot  = issuing ? slot_v  : '0;
    assign bus.out_shift = issuing ? shift_v : '0;
    assign bus.out_mask  = issuing ? mask_v  : '0;
    assign bus.out_beat  = issuing ? beat    : '0;
    assign bus.out_last  = issuing & last;
    assign busy          = issuing;
    assign done          = done_q;
endmodule

// File: tb/tb_scpad_tile_sequencer.sv
// tb/tb_scpad_tile_sequencer.sv - scoreboard bench for scpad_tile_sequencer against an element-placement model
module tb_scpad_tile_sequencer;
    localparam int NC = 32;
    localparam int RW = 14;
    localparam int CW = 5;
    localparam int DW = 5;

    typedef struct {
        logic [NC*RW-1:0] slot;
        logic [NC*CW-1:0] shift;
        logic [NC-1:0]    mask;
        logic [DW-1:0]    beat;
        logic             last;
        logic             write;
    } beat_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic busy;
    logic done;

    int total = 0;
    int bad = 0;
    int stall = 0;
    bit rdy_rand = 1'b0;
    beat_t exp_q[$];
    bit exp_done = 1'b0;
    bit acc_pend = 1'b0;

    always #5 CLK = ~CLK;

    scpad_tile_sequencer_if #(.NUM_COLS(NC), .ROW_IDX_WIDTH(RW), .COL_IDX_WIDTH(CW), .MAX_DIM_WIDTH(DW)) bus ();

    scpad_tile_sequencer #(.NUM_COLS(NC), .ROW_IDX_WIDTH(RW), .COL_IDX_WIDTH(CW), .MAX_DIM_WIDTH(DW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave),
        .busy (busy),
        .done (done)
    );

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Model: place every tile element (r,c) at bank (r+c) mod NC and read back the swept line.
    task automatic push_tile(input int base, input int rm, input int cm, input int tr, input int wr);
        int nbeats;
        nbeats = (tr != 0) ? cm + 1 : rm + 1;
        for (int k = 0; k < nbeats; k++) begin
            beat_t e;
            e.slot  = '0;
            e.shift = '0;
            e.mask  = '0;
            for (int i = 0; i < NC; i++) begin
                int bank;
                int row;
                bank = (i + k) % NC;
                row  = (tr != 0) ? (base + i) % (1 << RW) : (base + k) % (1 << RW);
                e.slot[bank*RW +: RW]  = RW'(row);
                e.shift[bank*CW +: CW] = CW'(i);
                e.mask[bank]           = (tr != 0) ? (i <= rm) : (i <= cm);
            end
            e.beat  = DW'(k);
            e.last  = (k == nbeats - 1);
            e.write = (wr != 0);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (stall > 0) begin
                bus.out_ready = 1'b0;
                stall--;
            end else begin
                bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin
        forever begin
            bit nxt_done;
            bit nxt_acc;
            @(negedge CLK);
            if (!nRST) begin
                check("rst_valid", bus.out_valid, 0);
                check("rst_req_ready", bus.req_ready, 1);
                check("rst_done", done, 0);
                check("rst_slot", bus.out_slot, 0);
                check("rst_misc", {bus.out_shift, bus.out_mask, bus.out_beat, bus.out_last, bus.out_write, busy}, 0);
                exp_q.delete();
                exp_done = 1'b0;
                acc_pend = 1'b0;
                continue;
            end
            nxt_done = 1'b0;
            check("done", done, exp_done);
            if (acc_pend) check("first_beat_latency", bus.out_valid, 1);
            if (bus.out_valid) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q[0];
                    check("slot", bus.out_slot, e.slot);
                    check("shift", bus.out_shift, e.shift);
                    check("mask", bus.out_mask, e.mask);
                    check("beat", bus.out_beat, e.beat);
                    check("last", bus.out_last, e.last);
                    check("write", bus.out_write, e.write);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        if (e.last) nxt_done = 1'b1;
                    end
                end
                check("busy_issue", busy, 1);
                check("req_ready_issue", bus.req_ready, 0);
            end else begin
                check("idle_slot", bus.out_slot, 0);
                check("idle_misc", {bus.out_shift, bus.out_mask, bus.out_beat, bus.out_last, bus.out_write}, 0);
                check("busy_idle", busy, 0);
                check("req_ready_idle", bus.req_ready, 1);
            end
            nxt_acc = bus.req_valid && bus.req_ready;
            if (nxt_acc)
                push_tile(int'(bus.req_base_row), int'(bus.req_rows_m1), int'(bus.req_cols_m1),
                          int'(bus.req_transpose), int'(bus.req_write));
            exp_done = nxt_done;
            acc_pend = nxt_acc;
        end
    end

    task automatic rand_fields(input int max_dim);
        bus.req_base_row  = RW'($urandom_range(0, (1 << RW) - 1));
        bus.req_rows_m1   = DW'($urandom_range(0, max_dim));
        bus.req_cols_m1   = DW'($urandom_range(0, max_dim));
        bus.req_transpose = 1'($urandom_range(0, 1));
        bus.req_write     = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        check(name, seen, 1);
    endtask

    task automatic send_tile(input int base, input int rm, input int cm, input int tr, input int wr,
                             input bit do_wait);
        bit accepted;
        accepted = 1'b0;
        @(posedge CLK);
        #1;
        bus.req_valid     = 1'b1;
        bus.req_base_row  = RW'(base);
        bus.req_rows_m1   = DW'(rm);
        bus.req_cols_m1   = DW'(cm);
        bus.req_transpose = tr[0];
        bus.req_write     = wr[0];
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge CLK);
            if (bus.req_ready) accepted = 1'b1;
        end
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        rand_fields(31);
        check("accept_seen", accepted, 1);
        if (do_wait) wait_done("done_seen");
    endtask

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_base_row  = '0;
        bus.req_rows_m1   = '0;
        bus.req_cols_m1   = '0;
        bus.req_transpose = 1'b0;
        bus.req_write     = 1'b0;
        #22;
        nRST = 1'b1;

        send_tile(100, 3, 7, 0, 1, 1'b1);
        send_tile(0, 31, 31, 1, 0, 1'b1);
        stall = 4;
        send_tile(5000, 1, 31, 0, 1, 1'b1);
        send_tile(16383, 1, 5, 0, 0, 1'b1);
        send_tile(16380, 31, 3, 1, 1, 1'b1);
        send_tile(77, 0, 0, 0, 1, 1'b1);
        send_tile(9, 0, 0, 1, 0, 1'b1);

        // Reset in the middle of a four-row tile.
        begin
            bit hit;
            hit = 1'b0;
            send_tile(300, 3, 15, 0, 1, 1'b0);
            for (int i = 0; i < 50 && !hit; i++) begin
                @(negedge CLK);
                if (bus.out_valid && bus.out_beat == 2) hit = 1'b1;
            end
            check("reached_beat2", hit, 1);
            #1;
            nRST = 1'b0;
            #1;
            check("async_rst_valid", bus.out_valid, 0);
            check("async_rst_req_ready", bus.req_ready, 1);
            check("async_rst_slot", bus.out_slot, 0);
            repeat (2) @(negedge CLK);
            #2;
            nRST = 1'b1;
        end
        send_tile(1234, 2, 9, 1, 0, 1'b1);

        // Back-to-back: req_valid stays high and fields churn while the first tile issues.
        begin
            int accepts;
            accepts = 0;
            @(posedge CLK);
            #1;
            bus.req_valid = 1'b1;
            rand_fields(7);
            for (int i = 0; i < 300 && accepts < 2; i++) begin
                @(negedge CLK);
                if (bus.req_ready) accepts++;
                @(posedge CLK);
                #1;
                if (accepts < 2) rand_fields(7);
            end
            bus.req_valid = 1'b0;
            check("b2b_accepts", accepts, 2);
            wait_done("b2b_done_seen");
        end

        rdy_rand = 1'b1;
        for (int t = 0; t < 15; t++) begin
            send_tile($urandom_range(0, (1 << RW) - 1), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
        end
        rdy_rand = 1'b0;
        repeat (3) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scpad_tile_sequencer.md
# scpad_tile_sequencer

Front-end tile sequencer for the AMP1 scratchpad. It accepts one tile descriptor (base row, tile dimensions, row-major or transposed access) and expands it into per-cycle SRAM beats, one row or one column per beat. Each beat carries per-bank slot, shift and valid vectors. It sits between the frontend arbiter and the SRAM controller/crossbar, and applies the diagonal bank swizzle that makes both row and column tile accesses conflict-free.

## Interface
Parameters:
- NUM_COLS, 32: banks per scratchpad row, power of 2.
- ROW_IDX_WIDTH, 14: slot index width (16384 rows of 64 B).
- COL_IDX_WIDTH, 5: clog2(NUM_COLS).
- MAX_DIM_WIDTH, 5: width of the tile-dimension fields.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  sequencer can accept a descriptor.
- req_base_row  in  ROW_IDX_WIDTH  scratchpad row holding tile row 0.
- req_rows_m1  in  MAX_DIM_WIDTH  tile rows minus 1.
- req_cols_m1  in  MAX_DIM_WIDTH  tile columns minus 1.
- req_transpose  in  1  0 = row beats, 1 = column beats.
- req_write  in  1  passed through to out_write.
- out_valid  out  1  beat valid.
- out_ready  in  1  SRAM controller accepts the beat.
- out_write  out  1  latched req_write.
- out_slot  out  NUM_COLS×ROW_IDX_WIDTH  per-bank row index (slot_mask).
- out_shift  out  NUM_COLS×COL_IDX_WIDTH  per-bank crossbar lane (shift_mask).
- out_mask  out  NUM_COLS  per-bank enable (valid_mask).
- out_beat  out  MAX_DIM_WIDTH  current beat index.
- out_last  out  1  final beat of the tile.
- busy  out  1  state is ISSUE.
- done  out  1  one-cycle pulse after the last beat completes.

## Operation
- Swizzle: tile element (r,c) is stored in row (base_row + r) mod 2^ROW_IDX_WIDTH, bank (c + r) mod NUM_COLS.
- Row mode, beat k (k = 0..rows_m1), for each bank b:
  - c = (b − k) mod NUM_COLS.
  - slot[b] = base_row + k.
  - shift[b] = c.
  - mask[b] = (c ≤ cols_m1).
- Column mode, beat k (k = 0..cols_m1), for each bank b:
  - r = (b − k) mod NUM_COLS.
  - slot[b] = base_row + r, computed modulo 2^ROW_IDX_WIDTH.
  - shift[b] = r.
  - mask[b] = (r ≤ rows_m1).
- Last beat index L = rows_m1 in row mode, cols_m1 in column mode. out_last = (beat == L).
- All subtraction and addition is unsigned, truncated to the field width; wrap-around is intentional.
- FSM:
  - IDLE: req_ready = 1. On req_valid: latch all req_* fields, set beat = 0, go to ISSUE.
  - ISSUE: out_valid = 1.
    - On out_ready && !out_last: beat++.
    - On out_ready && out_last: go to IDLE and assert done for one cycle.
- Outputs are functions of registered state only; there is no combinational path from inputs to outputs.
- req_* fields are ignored while in ISSUE.
- When out_valid = 0, out_slot, out_shift, out_mask, out_beat, out_last and out_write are all 0.

## Timing
- Reset: state = IDLE, beat = 0, descriptor registers = 0, so req_ready = 1 and every other output = 0. Assertion takes effect immediately, including mid-tile: the tile is dropped and no done pulse is issued.
- Latency: descriptor accepted at edge N → first beat has out_valid = 1 in cycle N+1.
- Throughput: one beat per cycle while out_ready = 1. A tile takes L+1 beats.
- Backpressure: while out_valid && !out_ready, all out_* fields hold stable and beat does not advance.
- Completion: last handshake at edge M → cycle M+1 has done = 1, busy = 0, req_ready = 1. The next descriptor is accepted no earlier than edge M+1, so there is a minimum one-cycle bubble between tiles.
- 1×1 tile: single beat, with out_last = 1 on beat 0.

## Test plan
- Row mode: base 100, rows_m1 = 3, cols_m1 = 7, out_ready = 1.
  - Exactly 4 beats.
  - Beat 1: all slots = 101, mask = 0x000001FE, shift[1] = 0, shift[8] = 7.
  - done pulses 1 cycle after beat 3.
- Column mode: base 0, 32×32 tile.
  - Beat 5: slot[b] = (b−5) mod 32, slot[0] = 27, shift[0] = 27, mask = 0xFFFFFFFF.
  - Beat 31 has out_last = 1.
- Backpressure: row mode 2×32, out_ready low for 3 cycles on beat 0.
  - Outputs stay stable and beat stays 0.
  - Then 2 beats complete, with no extra or skipped beat.
- Wrap-around: base 16383, rows_m1 = 1, row mode → beat 0 slot = 16383, beat 1 slot = 0.
- Reset mid-tile: assert nRST low during beat 2 of a 4-row tile.
  - Outputs go to 0 asynchronously, req_ready = 1 after release, done is never asserted.
  - A new tile then runs correctly.
- Back-to-back: req_valid held high with two descriptors.
  - Second is accepted in the done cycle.
  - Its first beat appears 1 cycle later.
  - req_* changes during ISSUE are ignored.
